shifter_seq_ctrl: RTL and testbench
===================================

Name: shifter_seq_ctrl

Overview:
- Command-driven sequencer for the team's 4-bit parallel-load/bidirectional shift register (ports clk, clr, D, D_sr, D_sl, ld, sr, sl, Q).
- Accepts one command at a time over a valid/ready handshake: load, shift right N or shift left N.
- Drives the shifter control and serial lines for the required number of cycles, then captures Q and pulses done.
- Sits between a host/register-file front end and the shifter instance.

Parameters:
- WIDTH, 4, shifter data width; must match the shifter.
- CNT_W, 3, width of the shift-count field; maximum shift is 2^CNT_W-1.

Ports:
- clk  input  1  system clock, rising edge.
- clr  input  1  asynchronous active-low reset.
- cmd_valid  input  1  command present.
- cmd_ready  output  1  controller can accept a command (high only in IDLE).
- cmd_op  input  2  00 LOAD, 01 SHR, 10 SHL, 11 ROTR (see Optional Feature).
- cmd_data  input  WIDTH  parallel load value (LOAD only).
- cmd_cnt  input  CNT_W  shift count (shift ops only).
- cmd_fill  input  1  serial bit shifted in (SHR/SHL only).
- sh_ld, sh_sr, sh_sl  output  1 each  to the shifter's ld/sr/sl; registered; at most one high per cycle.
- sh_d  output  WIDTH  to shifter D; registered.
- sh_d_sr, sh_d_sl  output  1 each  to shifter D_sr/D_sl; registered.
- sh_q  input  WIDTH  from shifter Q.
- done  output  1  one-cycle completion pulse.
- res  output  WIDTH  registered Q snapshot; updated in the done cycle; held otherwise.
- err  output  1  one-cycle pulse with done when the command was illegal.

Behaviour:
- Shifter convention: sr moves toward the LSB with D_sr entering the MSB; sl moves toward the MSB with D_sl entering the LSB. Shifter and controller share clk/clr.
- Reset (clr low, any time including mid-command): state IDLE, all outputs 0 except cmd_ready=1 after release, res=0, count cleared. No partial command resumes.
- States: IDLE, RUN, CAPT.
- IDLE:
  - Accept when cmd_valid && cmd_ready at edge T.
  - Latch op/data/cnt/fill. Next state is RUN, or CAPT directly if op is SHR/SHL with cnt=0 or the op is illegal.
- RUN:
  - LOAD: sh_ld=1 and sh_d=cmd_data for exactly 1 cycle (cycle T+1).
  - SHR/SHL: sh_sr or sh_sl=1 for exactly cnt consecutive cycles (T+1..T+cnt). sh_d_sr/sh_d_sl=fill.
  - Down-counter decrements each cycle; leave RUN after the last active cycle.
  - Counts >= WIDTH fully flush the register with fill.
- CAPT: all shifter controls 0. Sample sh_q into res at the closing edge. Go to IDLE.
- done: registered pulse in the first IDLE cycle after CAPT, coincident with the new res value. cmd_ready is also high in that cycle, so back-to-back commands are legal.
- Latency (accept edge T to done cycle):
  - LOAD: T+3.
  - Shift by cnt: T+cnt+3.
  - cnt=0 or illegal: T+2.
- cmd_valid while not ready is ignored. The command must be held by the source (standard valid/ready).
- Shifter controls idle low in IDLE; sh_d holds its last value.

Optional Feature:
- Macro SHIFTER_SEQ_ROTATE_EN.
- Defined: op 11 = rotate right by cnt. RUN drives sh_sr=1 with sh_d_sr combinationally from sh_q[0] each cycle. Timing is identical to SHR.
- Undefined: op 11 is illegal. No shifter activity; done and err pulse at T+2; res is recaptured unchanged from Q.

Decomposition:
- Shared package shifter_pkg:
  - op encodings (OP_LOAD, OP_SHR, OP_SHL, OP_ROTR);
  - state enum;
  - default WIDTH/CNT_W constants.
- Single module; no sub-module needed. The down-counter stays inline.
- The bench instantiates this block together with the existing shifter.

Test Plan:
- Reset, then LOAD data=0110 accepted at T -> sh_ld high only at T+1; done at T+3; res=0110.
- From 0110, SHR cnt=1 fill=1 -> sh_sr high 1 cycle; res=1011 at T+4.
- From 1011, SHL cnt=2 fill=0 -> sh_sl high 2 cycles; res=1100 at T+5. Immediately follow with a new command in the done cycle -> accepted.
- SHR cnt=0 -> no ld/sr/sl activity; done at T+2; res=Q unchanged. SHL cnt=7 fill=1 -> res=1111.
- Assert clr low during the third cycle of SHR cnt=5 -> outputs 0, state IDLE. After release, LOAD 1001 completes normally with res=1001.
- Op 11 on 0110 cnt=1:
  - with SHIFTER_SEQ_ROTATE_EN: res=0011, err=0;
  - without: done+err at T+2, res=0110.

Source files
------------

// File: rtl/shifter_pkg.sv
// Shared definitions for the shift-register command sequencer: command op
// encodings, controller state encoding and default datapath sizes.
package shifter_pkg;

    // Default sizes; WIDTH must match the attached shifter instance.
    localparam int WIDTH_DEF = 4;
    localparam int CNT_W_DEF = 3;

    // Command op encodings carried on cmd_op.
    localparam logic [1:0] OP_LOAD = 2'b00;
    localparam logic [1:0] OP_SHR  = 2'b01;
    localparam logic [1:0] OP_SHL  = 2'b10;
    localparam logic [1:0] OP_ROTR = 2'b11;

    // Controller states, also visible on the dbg_state port.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_CAPT = 2'd2
    } state_e;

endpackage

// File: rtl/shifter_seq_ctrl.sv
// Command sequencer for the 4-bit parallel-load / bidirectional shifter.
// Takes one LOAD / SHR / SHL (/ ROTR) command at a time, drives the shifter
// controls for the required cycles, then snapshots Q into res and pulses done.
//
// Build option: define SHIFTER_SEQ_ROTATE_EN to make op 11 a rotate-right
// (sh_d_sr fed from sh_q[0]). Without it op 11 is illegal and only
// reports done+err with res recaptured from Q.
//
// Handshake: a command transfers on a rising edge where cmd_valid and
// cmd_ready are both high; the source holds cmd_* stable until then.
// cmd_ready is high only in IDLE (including the done cycle), so a new
// command may be presented back-to-back with done.
module shifter_seq_ctrl
    import shifter_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [WIDTH-1:0] cmd_data,
    input  logic [CNT_W-1:0] cmd_cnt,
    input  logic             cmd_fill,
    output logic             sh_ld,
    output logic             sh_sr,
    output logic             sh_sl,
    output logic [WIDTH-1:0] sh_d,
    output logic             sh_d_sr,
    output logic             sh_d_sl,
    input  logic [WIDTH-1:0] sh_q,
    output logic             done,
    output logic [WIDTH-1:0] res,
    output logic             err,
    output logic [1:0]       dbg_state
);

    localparam logic [1:0] S_IDLE = ST_IDLE;
    localparam logic [1:0] S_RUN  = ST_RUN;
    localparam logic [1:0] S_CAPT = ST_CAPT;

    localparam logic [CNT_W-1:0] CNT_ZERO = '0;
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [1:0]       state;
    logic [CNT_W-1:0] cnt_q;
    logic             illegal_q;
    logic             d_sr_q;
    logic             accept;
    logic             op_right;
    logic             op_illegal;
    logic             rot_q;

    // Decode which ops move toward the LSB and which are illegal in this build.
`ifdef SHIFTER_SEQ_ROTATE_EN
    assign op_right   = (cmd_op == OP_SHR) || (cmd_op == OP_ROTR);
    assign op_illegal = 1'b0;
`else
    assign op_right   = (cmd_op == OP_SHR);
    assign op_illegal = (cmd_op == OP_ROTR);
`endif

    assign cmd_ready = (state == S_IDLE) && clr;
    assign accept    = cmd_valid && cmd_ready;
    assign dbg_state = state;

    // Rotate feeds the LSB back into the MSB; otherwise the registered fill.
`ifdef SHIFTER_SEQ_ROTATE_EN
    assign sh_d_sr = rot_q ? sh_q[0] : d_sr_q;
`else
    assign sh_d_sr = d_sr_q;
`endif

    // Sequencer FSM, shift down-counter and all registered outputs.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state     <= S_IDLE;
            cnt_q     <= '0;
            illegal_q <= 1'b0;
            rot_q     <= 1'b0;
            sh_ld     <= 1'b0;
            sh_sr     <= 1'b0;
            sh_sl     <= 1'b0;
            sh_d      <= '0;
            d_sr_q    <= 1'b0;
            sh_d_sl   <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
            res       <= '0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        illegal_q <= op_illegal;
                        rot_q     <= (cmd_op == OP_ROTR) && !op_illegal;
                        if (op_illegal) begin
                            state <= S_CAPT;
                        end else if (cmd_op == OP_LOAD) begin
                            // Zero count: the single load cycle is also the last.
                            sh_ld <= 1'b1;
                            sh_d  <= cmd_data;
                            cnt_q <= CNT_ZERO;
                            state <= S_RUN;
                        end else if (cmd_cnt == CNT_ZERO) begin
                            state <= S_CAPT;
                        end else if (op_right) begin
                            sh_sr  <= 1'b1;
                            d_sr_q <= cmd_fill;
                            cnt_q  <= cmd_cnt;
                            state  <= S_RUN;
                        end else begin
                            sh_sl   <= 1'b1;
                            sh_d_sl <= cmd_fill;
                            cnt_q   <= cmd_cnt;
                            state   <= S_RUN;
                        end
                    end
                end
                S_RUN: begin
                    // Shifts run cnt active cycles plus one settle cycle at cnt_q==0.
                    if (cnt_q == CNT_ZERO) begin
                        sh_ld   <= 1'b0;
                        sh_sr   <= 1'b0;
                        sh_sl   <= 1'b0;
                        d_sr_q  <= 1'b0;
                        sh_d_sl <= 1'b0;
                        rot_q   <= 1'b0;
                        state   <= S_CAPT;
                    end else begin
                        cnt_q <= cnt_q - CNT_ONE;
                        if (cnt_q == CNT_ONE) begin
                            sh_sr <= 1'b0;
                            sh_sl <= 1'b0;
                        end
                    end
                end
                S_CAPT: begin
                    res   <= sh_q;
                    done  <= 1'b1;
                    err   <= illegal_q;
                    rot_q <= 1'b0;
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_shifter_seq_ctrl.sv
// Bench for shifter_seq_ctrl with a behavioural 4-bit shifter attached.
// Expected {err,res}, latency and control activity are queued when a command
// is driven and compared when done pulses.
module tb_shifter_seq_ctrl;
    import shifter_pkg::*;

    localparam int WIDTH = 4;
    localparam int CNT_W = 3;
    localparam int W     = WIDTH + 1;
`ifdef SHIFTER_SEQ_ROTATE_EN
    localparam bit ROT_EN = 1'b1;
`else
    localparam bit ROT_EN = 1'b0;
`endif

    // ---------------- clock / reset / signals ----------------
    logic             clk = 1'b0;
    logic             clr = 1'b0;
    logic             cmd_valid = 1'b0;
    logic             cmd_ready;
    logic [1:0]       cmd_op = 2'b00;
    logic [WIDTH-1:0] cmd_data = '0;
    logic [CNT_W-1:0] cmd_cnt = '0;
    logic             cmd_fill = 1'b0;
    logic             sh_ld, sh_sr, sh_sl, sh_d_sr, sh_d_sl;
    logic [WIDTH-1:0] sh_d, res, q;
    logic             done, err;
    logic [1:0]       dbg_state;

    always #5 clk = ~clk;

    shifter_seq_ctrl #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .clr(clr),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_data(cmd_data), .cmd_cnt(cmd_cnt), .cmd_fill(cmd_fill),
        .sh_ld(sh_ld), .sh_sr(sh_sr), .sh_sl(sh_sl),
        .sh_d(sh_d), .sh_d_sr(sh_d_sr), .sh_d_sl(sh_d_sl),
        .sh_q(q), .done(done), .res(res), .err(err), .dbg_state(dbg_state)
    );

    // The shifter being sequenced.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr)       q <= '0;
        else if (sh_ld) q <= sh_d;
        else if (sh_sr) q <= {sh_d_sr, q[WIDTH-1:1]};
        else if (sh_sl) q <= {q[WIDTH-2:0], sh_d_sl};
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- checking ----------------
    int n_chk = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    endtask

    // ---------------- scoreboard ----------------
    logic [W-1:0]     exp_q[$];
    int               lat_q[$];
    int               act_q[$];
    logic [WIDTH-1:0] model_reg = '0;

    int               acc_cyc = 0;
    int               done_cyc = -10;
    int               ld_n = 0, sr_n = 0, sl_n = 0, bad_n = 0;
    logic [1:0]       cur_op = 2'b00;
    logic [WIDTH-1:0] cur_data = '0;
    logic             cur_fill = 1'b0;
    logic [W-1:0]     e;

    always @(negedge clk) begin
        if (clr) begin
            if (sh_ld) ld_n++;
            if (sh_sr) sr_n++;
            if (sh_sl) sl_n++;
            if (int'(sh_ld) + int'(sh_sr) + int'(sh_sl) > 1) bad_n++;
            if (sh_ld && sh_d != cur_data) bad_n++;
            if (sh_sr && sh_d_sr != ((cur_op == OP_ROTR) ? q[0] : cur_fill)) bad_n++;
            if (sh_sl && sh_d_sl != cur_fill) bad_n++;
            if (done) begin
                if (exp_q.size() == 0) begin
                    chk("spurious_done", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("res", int'(res), int'(e[WIDTH-1:0]));
                    chk("err", int'(err), int'(e[WIDTH]));
                    chk("latency", cyc - acc_cyc + 1, lat_q.pop_front());
                    chk("activity", ld_n * 64 + sr_n * 8 + sl_n, act_q.pop_front());
                    chk("ctrl_bad", bad_n, 0);
                end
                done_cyc = cyc;
            end
            if (cmd_valid && cmd_ready) begin
                acc_cyc  = cyc + 1;
                cur_op   = cmd_op;
                cur_data = cmd_data;
                cur_fill = cmd_fill;
                ld_n = 0; sr_n = 0; sl_n = 0; bad_n = 0;
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic send(input logic [1:0] op, input logic [WIDTH-1:0] data,
                        input int cnt, input logic fill);
        logic [WIDTH-1:0] r;
        logic             ill;
        int               lat, act;
        r   = model_reg;
        ill = (op == OP_ROTR) && !ROT_EN;
        lat = 2;
        act = 0;
        if (op == OP_LOAD) begin
            r = data; lat = 3; act = 64;
        end else if (!ill) begin
            for (int i = 0; i < cnt; i++) begin
                if (op == OP_SHR)      r = {fill, r[WIDTH-1:1]};
                else if (op == OP_SHL) r = {r[WIDTH-2:0], fill};
                else                   r = {r[0], r[WIDTH-1:1]};
            end
            if (cnt > 0) lat = cnt + 3;
            act = (op == OP_SHL) ? cnt : cnt * 8;
        end
        exp_q.push_back({ill, r});
        lat_q.push_back(lat);
        act_q.push_back(act);
        model_reg = r;

        cmd_op = op; cmd_data = data; cmd_cnt = CNT_W'(cnt); cmd_fill = fill;
        cmd_valid = 1'b1;
        for (int t = 0; t < 100 && !cmd_ready; t++) begin
            @(posedge clk); #1;
        end
        if (!cmd_ready) begin
            chk("accept_timeout", 0, 1);
            void'(exp_q.pop_back()); void'(lat_q.pop_back()); void'(act_q.pop_back());
        end else begin
            @(posedge clk); #1;
        end
        cmd_valid = 1'b0;
    endtask

    task automatic wait_idle();
        for (int t = 0; t < 100 && exp_q.size() != 0; t++) begin
            @(posedge clk); #1;
        end
        if (exp_q.size() != 0) begin
            chk("done_timeout", exp_q.size(), 0);
            exp_q.delete(); lat_q.delete(); act_q.delete();
        end
        repeat (2) @(posedge clk);
        #1;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        clr = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_outputs", {sh_ld, sh_sr, sh_sl, done, err, cmd_ready}, 0);
        chk("reset_res", int'(res), 0);
        chk("reset_state", int'(dbg_state), int'(ST_IDLE));
        clr = 1'b1;
        #1;
        chk("ready_after_reset", int'(cmd_ready), 1);

        send(OP_LOAD, 4'b0110, 0, 1'b0);
        wait_idle();
        send(OP_SHR, 4'b0000, 1, 1'b1);
        wait_idle();
        chk("model_1011", int'(model_reg), 4'b1011);

        // SHL 2 then a command presented while busy, taken in the done cycle.
        send(OP_SHL, 4'b0000, 2, 1'b0);
        send(OP_SHR, 4'b0000, 0, 1'b1);
        chk("back_to_back", acc_cyc, done_cyc + 1);
        send(OP_SHL, 4'b0000, 7, 1'b1);
        wait_idle();

        // Reset in the third cycle of a long shift.
        send(OP_SHR, 4'b0000, 5, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        clr = 1'b0;
        #2;
        chk("midrst_outputs", {sh_ld, sh_sr, sh_sl, done, err, cmd_ready}, 0);
        chk("midrst_state", int'(dbg_state), int'(ST_IDLE));
        chk("midrst_res", int'(res), 0);
        exp_q.delete(); lat_q.delete(); act_q.delete();
        model_reg = '0;
        @(posedge clk); #1;
        clr = 1'b1;
        #1;
        chk("ready_after_midrst", int'(cmd_ready), 1);
        send(OP_LOAD, 4'b1001, 0, 1'b0);
        wait_idle();

        // Op 11 on 0110 by one.
        send(OP_LOAD, 4'b0110, 0, 1'b0);
        send(OP_ROTR, 4'b0000, 1, 1'b0);
        wait_idle();

        // Random back-to-back traffic.
        for (int i = 0; i < 16; i++) begin
            send(2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)),
                 $urandom_range(0, 7), 1'($urandom_range(0, 1)));
        end
        wait_idle();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_chk);
        $fatal(1);
    end

endmodule
